rat_uart_tx: RTL and testbench

Port-mapped 8N1 UART transmitter for the RAT MCU I/O bus. The MCU writes bytes to a data port ID; the block queues them in a small FIFO and serializes them LSB-first on `tx`. A status byte is driven for the top-level input-port mux, so firmware can poll empty/full/busy/overflow. The block sits beside the LED, SSEG and speaker output registers and is clocked by the 100 MHz board clock.

---
 rtl/rat_io_pkg.sv | 24 ++
 rtl/rat_uart_tx_if.sv | 10 +
 rtl/rat_uart_tx_fifo.sv | 42 ++++
 rtl/rat_uart_tx.sv | 151 +++++++++++++++
 tb/tb_rat_uart_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rat_io_pkg.sv
// rtl/rat_io_pkg.sv - RAT MCU I/O port map, UART TX state type and status bit indices
package rat_io_pkg;

  localparam logic [7:0] PORT_SWITCHES    = 8'h20;
  localparam logic [7:0] PORT_LEDS        = 8'h40;
  localparam logic [7:0] PORT_KEYPAD      = 8'h80;
  localparam logic [7:0] PORT_SSEG        = 8'h81;
  localparam logic [7:0] PORT_SPEAKER     = 8'h82;
  localparam logic [7:0] PORT_UART_DATA   = 8'h83;
  localparam logic [7:0] PORT_UART_STATUS = 8'h84;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_BUSY_BIT     = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;

endpackage

// File: rtl/rat_uart_tx_if.sv
// rtl/rat_uart_tx_if.sv - RAT MCU port bus as seen by one I/O peripheral
interface rat_uart_tx_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] status;

  modport master (output port_id, output out_port, output io_strb, input status);
  modport slave  (input port_id, input out_port, input io_strb, output status);
endinterface

// File: rtl/rat_uart_tx_fifo.sv
// rtl/rat_uart_tx_fifo.sv - generic synchronous FIFO with show-ahead read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/rat_uart_tx.sv
// rtl/rat_uart_tx.sv - port-mapped 8N1 UART transmitter with queued writes and status byte
module rat_uart_tx
  import rat_io_pkg::*;
#(
  parameter int          CLK_FREQ       = 100_000_000,
  parameter int          BAUD           = 115200,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [7:0]  DATA_PORT_ID   = PORT_UART_DATA,
  parameter logic [7:0]  STATUS_PORT_ID = PORT_UART_STATUS
) (
  input  logic           clk,
  input  logic           reset_n,
  rat_uart_tx_if.slave   bus,
  output logic           tx,
  output logic           busy
);
  localparam int             DIV       = CLK_FREQ / BAUD;
  localparam int             CW        = $clog2(DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);

  uart_tx_state_t state_q;
  logic [CW-1:0]  baud_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           wr_q, st_q, ovf_q, ovf_d;
  logic           wr, st_wr, wr_edge, clr_edge, baud_wrap;
  logic           fifo_full, fifo_empty, push, pop;
  logic [7:0]     fifo_dout;
  logic [7:0]     status_w;

  // The MCU strobe spans several clk cycles; only its first cycle counts.
  assign wr       = bus.io_strb && (bus.port_id == DATA_PORT_ID);
  assign st_wr    = bus.io_strb && (bus.port_id == STATUS_PORT_ID);
  assign wr_edge  = wr && !wr_q;
  assign clr_edge = st_wr && !st_q;

  assign push      = wr_edge && !fifo_full;
  assign baud_wrap = (baud_q == BAUD_LAST);
  assign pop       = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_wrap));

  always_comb begin
    ovf_d = ovf_q;
    if (clr_edge)              ovf_d = 1'b0;
    if (wr_edge && fifo_full)  ovf_d = 1'b1;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (bus.out_port),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= 1'b0;
      st_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr;
      st_q  <= st_wr;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_dout;
            state_q <= START;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_q <= '0;
            // A queued byte starts its frame with no idle gap.
            if (pop) begin
              shift_q <= fifo_dout;
              state_q <= START;
              bit_q   <= '0;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

  always_comb begin
    status_w                      = '0;
    status_w[STATUS_EMPTY_BIT]    = fifo_empty;
    status_w[STATUS_FULL_BIT]     = fifo_full;
    status_w[STATUS_BUSY_BIT]     = busy;
    status_w[STATUS_OVERFLOW_BIT] = ovf_q;
  end

  assign bus.status = status_w;
endmodule

// File: tb/tb_rat_uart_tx.sv
// tb/tb_rat_uart_tx.sv - randomized self-checking bench for rat_uart_tx with a line-level frame decoder
module tb_rat_uart_tx;
  import rat_io_pkg::*;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tx, busy;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  logic [7:0] exp_q[$];
  bit         mon_abort;

  rat_uart_tx_if bus();

  rat_uart_tx #(
    .CLK_FREQ       (1_000_000),
    .BAUD           (100_000),
    .FIFO_DEPTH     (4),
    .DATA_PORT_ID   (8'h83),
    .STATUS_PORT_ID (8'h84)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!reset_n) mon_abort = 1'b1;
    end
  endtask

  // Line decoder: samples each bit in the middle of its period.
  initial begin
    int         t0;
    logic       s_bit, p_bit;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0) begin
        t0 = cyc;
        mon_abort = 1'b0;
        mon_wait(DIV / 2);
        s_bit = tx;
        for (int k = 0; k < 8; k++) begin
          mon_wait(DIV);
          d[k] = tx;
        end
        mon_wait(DIV);
        p_bit = tx;
        mon_wait(DIV / 2 - 1);
        if (!mon_abort) begin
          check("start_bit", s_bit, 1'b0);
          check("stop_bit", p_bit, 1'b1);
          rx_q.push_back(d);
          rx_start_q.push_back(t0);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] pid, input logic [7:0] data, input int len,
                           output int edge_cyc);
    bus.port_id  = pid;
    bus.out_port = data;
    bus.io_strb  = 1'b1;
    edge_cyc     = cyc;
    repeat (len) @(negedge clk);
    bus.io_strb = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int waited);
    waited = 0;
    while ((busy !== 1'b0 || bus.status[STATUS_EMPTY_BIT] !== 1'b1) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= budget) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    rx_start_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         c, c0, w, n;
    logic [7:0] b;
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    bus.io_strb  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_status", bus.status, 8'h01);
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte with a 2-cycle strobe
    c = cyc;
    bus.port_id  = PORT_UART_DATA;
    bus.out_port = 8'hA5;
    bus.io_strb  = 1'b1;
    @(negedge clk);
    check("push_visible", bus.status, 8'h00);
    @(negedge clk);
    bus.io_strb = 1'b0;
    check("start_tx", tx, 1'b0);
    check("start_status", bus.status, 8'h05);
    wait_idle(400, w);
    check("busy_fall", cyc - c, 2 + FRAME);
    exp_q.push_back(8'hA5);
    if (rx_start_q.size() > 0) check("start_latency", rx_start_q[0] - c, 2);
    check_rx("single");

    // Strobe held 5 cycles
    exp_q.push_back(8'h3C);
    bus_write(PORT_UART_DATA, 8'h3C, 5, c);
    check("stretch_status", bus.status, 8'h05);
    wait_idle(400, w);
    check_rx("stretch");

    // Back-to-back frames
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    bus_write(PORT_UART_DATA, 8'h00, 2, c);
    bus_write(PORT_UART_DATA, 8'hFF, 2, c);
    bus_write(PORT_UART_DATA, 8'h55, 2, c);
    wait_idle(800, w);
    check("b2b_status", bus.status, 8'h01);
    for (int i = 1; i < rx_start_q.size(); i++)
      check("b2b_spacing", rx_start_q[i] - rx_start_q[i-1], FRAME);
    check_rx("b2b");

    // Overflow: one on the line, four queued, sixth dropped
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) exp_q.push_back(b);
      bus_write(PORT_UART_DATA, b, 2, c);
    end
    check("ovf_status", bus.status, 8'h0E);
    bus_write(PORT_UART_STATUS, 8'($urandom), 2, c);
    check("ovf_clear", bus.status, 8'h06);
    wait_idle(1000, w);
    check_rx("ovf");

    // Reset during data bit 3 with a second byte queued
    bus_write(PORT_UART_DATA, 8'($urandom), 2, c0);
    bus_write(PORT_UART_DATA, 8'($urandom), 2, c);
    while (cyc < c0 + 2 + 4 * DIV + 3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_status", bus.status, 8'h01);
    check("midrst_busy", busy, 1'b0);
    repeat (12) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_noframe", rx_q.size(), 0);
    check("midrst_idle", bus.status, 8'h01);
    check_rx("midrst");

    // Strobes on other port IDs
    bus_write(PORT_LEDS, 8'($urandom), $urandom_range(2, 3), c);
    bus_write(PORT_SPEAKER, 8'($urandom), $urandom_range(2, 3), c);
    bus_write(PORT_UART_STATUS, 8'($urandom), $urandom_range(2, 3), c);
    repeat (200) @(negedge clk);
    check("decode_status", bus.status, 8'h01);
    check_rx("decode");

    // Random bursts: capacity while the line is busy is 1 + depth
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (i < 5) exp_q.push_back(b);
        bus_write(PORT_UART_DATA, b, $urandom_range(2, 5), c);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      check("burst_ovf", bus.status[STATUS_OVERFLOW_BIT], n > 5);
      check("burst_full", bus.status[STATUS_FULL_BIT], n >= 5);
      bus_write(PORT_UART_STATUS, 8'($urandom), 2, c);
      check("burst_clr", bus.status[STATUS_OVERFLOW_BIT], 1'b0);
      wait_idle(1200, w);
      check_rx("burst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
